// File: rtl/bresenham_line_drawer_pkg.sv
// Shared types for the line drawer and its neighbours in the raster pipeline:
// point/triangle structs, coordinate width and the line-drawer state encoding.
package bresenham_line_drawer_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } Point2D;

    typedef struct packed {
        Point2D a;
        Point2D b;
        Point2D c;
    } Triangle2D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PLOT  = 2'd2,
        ST_DONE  = 2'd3
    } line_state_t;

endpackage

// File: rtl/bresenham_line_drawer_step.sv
// One Bresenham step: from the current point and error term, produce the
// next point and error. Purely combinational so it can be checked on its own.
module bresenham_step
    import bresenham_line_drawer_pkg::*;
(
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic signed [COORD_W+1:0] err,
    input  logic                      sx_neg,
    input  logic                      sy_neg,
    input  logic signed [COORD_W:0]   dx,
    input  logic signed [COORD_W:0]   dy,
    output logic [COORD_W-1:0]        x_next,
    output logic [COORD_W-1:0]        y_next,
    output logic signed [COORD_W+1:0] err_next
);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_e2w;
    logic signed [COORD_W+2:0] dy_e2w;
    logic signed [COORD_W+1:0] dx_ew;
    logic signed [COORD_W+1:0] dy_ew;
    logic                      step_x;
    logic                      step_y;

    // Both axis decisions look at the pre-update error; the two corrections add together.
    always_comb begin
        e2       = signed'({err[COORD_W+1], err}) <<< 1;
        dx_e2w   = signed'({{2{dx[COORD_W]}}, dx});
        dy_e2w   = signed'({{2{dy[COORD_W]}}, dy});
        dx_ew    = signed'({dx[COORD_W], dx});
        dy_ew    = signed'({dy[COORD_W], dy});
        step_x   = (e2 >= dy_e2w);
        step_y   = (e2 <= dx_e2w);
        err_next = err;
        x_next   = x;
        y_next   = y;
        if (step_x) begin
            err_next = err_next + dy_ew;
            x_next   = sx_neg ? (x - 1'b1) : (x + 1'b1);
        end
        if (step_y) begin
            err_next = err_next + dx_ew;
            y_next   = sy_neg ? (y - 1'b1) : (y + 1'b1);
        end
    end

endmodule

// File: rtl/bresenham_line_drawer.sv
// Bresenham line drawer: walks p->q one point per accepted pixel handshake.
// pixel_valid/pixel_ready: a pixel transfers on any cycle where both are high;
// while valid is high and ready is low, pixel and all internal state hold.
// Optional build macro BRESENHAM_CLIP_EN: points outside FB_WIDTH x FB_HEIGHT
// are stepped through silently (valid low, one point per cycle).
module bresenham_line_drawer
    import bresenham_line_drawer_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  Point2D      p,
    input  Point2D      q,
    input  logic        pixel_ready,
    output logic        pixel_valid,
    output Point2D      pixel,
    output logic        busy,
    output logic        done,
    output line_state_t state_dbg
);

    line_state_t               state;
    line_state_t               state_next;
    Point2D                    cur;
    Point2D                    q_r;
    logic signed [COORD_W:0]   dx_r;
    logic signed [COORD_W:0]   dy_r;
    logic signed [COORD_W+1:0] err_r;
    logic                      sx_neg_r;
    logic                      sy_neg_r;

    logic [COORD_W-1:0]        x_next;
    logic [COORD_W-1:0]        y_next;
    logic signed [COORD_W+1:0] err_next;
    logic signed [COORD_W:0]   diff_x;
    logic signed [COORD_W:0]   diff_y;
    logic signed [COORD_W:0]   abs_dx;
    logic signed [COORD_W:0]   abs_dy;
    logic                      visible;
    logic                      advance;
    logic                      at_end;

    // Reject framebuffer sizes that the coordinate width cannot address.
    if (FB_WIDTH < 1 || FB_WIDTH > (1 << COORD_W) ||
        FB_HEIGHT < 1 || FB_HEIGHT > (1 << COORD_W)) begin : g_bad_fb_dims
        $error("bresenham_line_drawer: framebuffer size out of coordinate range");
    end

    bresenham_step u_step (
        .x        (cur.x),
        .y        (cur.y),
        .err      (err_r),
        .sx_neg   (sx_neg_r),
        .sy_neg   (sy_neg_r),
        .dx       (dx_r),
        .dy       (dy_r),
        .x_next   (x_next),
        .y_next   (y_next),
        .err_next (err_next)
    );

    // Setup arithmetic and the visibility/advance decision for the current point.
    always_comb begin
        diff_x = signed'({1'b0, q_r.x}) - signed'({1'b0, cur.x});
        diff_y = signed'({1'b0, q_r.y}) - signed'({1'b0, cur.y});
        abs_dx = diff_x[COORD_W] ? -diff_x : diff_x;
        abs_dy = diff_y[COORD_W] ? -diff_y : diff_y;
        at_end = (cur == q_r);
`ifdef BRESENHAM_CLIP_EN
        visible = (int'(cur.x) < FB_WIDTH) && (int'(cur.y) < FB_HEIGHT);
        advance = visible ? pixel_ready : 1'b1;
`else
        visible = 1'b1;
        advance = pixel_ready;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        state_next  = state;
        pixel_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                state_next = ST_PLOT;
            end
            ST_PLOT: begin
                pixel_valid = visible;
                if (advance && at_end) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch endpoints, derive step terms, walk the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= '0;
            q_r      <= '0;
            dx_r     <= '0;
            dy_r     <= '0;
            err_r    <= '0;
            sx_neg_r <= 1'b0;
            sy_neg_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur <= p;
                        q_r <= q;
                    end
                end
                ST_SETUP: begin
                    sx_neg_r <= (q_r.x < cur.x);
                    sy_neg_r <= (q_r.y < cur.y);
                    dx_r     <= abs_dx;
                    dy_r     <= -abs_dy;
                    err_r    <= signed'({abs_dx[COORD_W], abs_dx})
                              - signed'({abs_dy[COORD_W], abs_dy});
                end
                ST_PLOT: begin
                    if (advance && !at_end) begin
                        cur.x <= x_next;
                        cur.y <= y_next;
                        err_r <= err_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pixel     = cur;
    assign state_dbg = state;

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed bench for bresenham_line_drawer with hand-computed pixel sequences.
module tb_bresenham_line_drawer;
    import bresenham_line_drawer_pkg::*;

    localparam int PW = 2 * COORD_W;

    logic        clk;
    logic        rst;
    logic        start;
    Point2D      p;
    Point2D      q;
    logic        pixel_ready;
    logic        pixel_valid;
    Point2D      pixel;
    logic        busy;
    logic        done;
    line_state_t state_dbg;

    int tests;
    int fails;
    int busy_cycles;
    logic [PW-1:0] exp_q[$];

    bresenham_line_drawer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .p           (p),
        .q           (q),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pt(input int x, input int y);
        logic [COORD_W-1:0] xv;
        logic [COORD_W-1:0] yv;
        xv = COORD_W'(x);
        yv = COORD_W'(y);
        return {xv, yv};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one line and score it against exp_q. mode 0: ready always high;
    // mode 1: ready high on every third plot cycle (1,0,0,1,...).
    task automatic run_line(input string tag, input int ax, input int ay,
                            input int bx, input int by, input int mode, input int exp_done);
        int   c;
        int   first_c;
        logic finished;
        logic held;
        logic [PW-1:0] held_pix;
        p           = pt(ax, ay);
        q           = pt(bx, by);
        pixel_ready = 1'b0;
        start       = 1'b1;
        tick;
        start = 1'b0;
        p     = pt($urandom_range(0, 1023), $urandom_range(0, 1023));
        q     = pt($urandom_range(0, 1023), $urandom_range(0, 1023));
        c     = 1;
        check({tag, "_setup_busy"}, 32'(busy), 32'd1);
        check({tag, "_setup_done"}, 32'(done), 32'd0);
        check({tag, "_setup_valid"}, 32'(pixel_valid), 32'd0);
        busy_cycles = 1;
        first_c     = 0;
        finished    = 1'b0;
        held        = 1'b0;
        held_pix    = '0;
        while (!finished && c < 80) begin
            tick;
            c++;
            pixel_ready = (mode == 0) ? 1'b1 : (((c - 2) % 3) == 0);
            if (busy) busy_cycles++;
            if (done) begin
                check({tag, "_done_cycle"}, 32'(c), 32'(exp_done));
                check({tag, "_pixel_count"}, 32'(exp_q.size()), 32'd0);
                finished = 1'b1;
            end else if (pixel_valid) begin
                if (first_c == 0) begin
                    first_c = c;
                    check({tag, "_first_valid_cycle"}, 32'(c), 32'd2);
                end
                if (held) check({tag, "_stall_hold"}, 32'(pixel), 32'(held_pix));
                if (pixel_ready) begin
                    if (exp_q.size() == 0) check({tag, "_extra_pixel"}, 32'(pixel), 32'hFFFFF);
                    else check({tag, "_pixel"}, 32'(pixel), 32'(exp_q.pop_front()));
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_pix = pixel;
                end
            end
        end
        if (!finished) check({tag, "_timeout"}, 32'd0, 32'd1);
        pixel_ready = 1'b0;
        tick;
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        start       = 1'b0;
        p           = '0;
        q           = '0;
        pixel_ready = 1'b0;
        tick;
        tick;
        check("rst_valid", 32'(pixel_valid), 32'd0);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        tick;

        // horizontal
        exp_q = '{pt(0,0), pt(1,0), pt(2,0), pt(3,0), pt(4,0)};
        run_line("horiz", 0, 0, 4, 0, 0, 7);

        // steep, both axes negative
        exp_q = '{pt(3,5), pt(3,4), pt(2,3), pt(2,2), pt(1,1), pt(1,0)};
        run_line("steep_neg", 3, 5, 1, 0, 0, 8);

        // shallow, positive slope
        exp_q = '{pt(0,0), pt(1,0), pt(2,1), pt(3,1), pt(4,2), pt(5,2)};
        run_line("shallow", 0, 0, 5, 2, 0, 8);

        // degenerate
        exp_q = '{pt(7,7)};
        run_line("degen", 7, 7, 7, 7, 0, 3);
        check("degen_busy_cycles", 32'(busy_cycles), 32'd3);

        // backpressure: handshakes on plot cycles 0,3,6,9
        exp_q = '{pt(0,0), pt(1,1), pt(2,2), pt(3,3)};
        run_line("backpressure", 0, 0, 3, 3, 1, 12);

        // reset during the 4th pixel
        p           = pt(0, 0);
        q           = pt(9, 0);
        pixel_ready = 1'b1;
        start       = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick;
            check("rstmid_pixel", 32'(pixel), 32'(pt(c - 2, 0)));
        end
        rst = 1'b1;
        #1;
        check("rstmid_valid", 32'(pixel_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_pixel0", 32'(pixel), 32'd0);
        tick;
        check("rstmid_done_held", 32'(done), 32'd0);
        rst         = 1'b0;
        pixel_ready = 1'b0;
        tick;
        exp_q = '{pt(5,3), pt(4,3), pt(3,3), pt(2,3)};
        run_line("after_rst", 5, 3, 2, 3, 0, 6);

        // right framebuffer edge
`ifdef BRESENHAM_CLIP_EN
        exp_q = '{pt(638,0), pt(639,0)};
`else
        exp_q = '{pt(638,0), pt(639,0), pt(640,0), pt(641,0)};
`endif
        run_line("clip_edge", 638, 0, 641, 0, 0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
